imm_gen_fifo: RTL and testbench
===============================

# imm_gen_fifo

Buffered, parametrised immediate generator for the RISC-V datapath. It accepts instruction words with an immediate-format select over a valid/ready handshake. For each word it decodes the I/S/B/J/U immediate, sign-extends it to XLEN, and queues the result with a sideband tag in a DEPTH-entry FIFO. The FIFO lets fetch/decode and the execute stage stall independently. The block sits between the instruction register and the ALU/branch operand muxes of the pipelined core.

## Interface
Parameters:
- XLEN, 32: output immediate width; legal values are 32 and 64.
- DEPTH, 2: FIFO entries; must be a power of two, 2 or more.
- TAG_W, 8: sideband tag width (PC index or ROB id), carried unchanged.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word.
- in_instr  in  32  instruction word; bits 6:0 are ignored.
- in_imm_src  in  3  format select: 0=I, 1=S, 2=B, 3=J, 4=U; 5–7 are illegal.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- out_imm  out  XLEN  sign-extended immediate of the head entry.
- out_tag  out  TAG_W  tag of the head entry.
- out_illegal  out  1  head entry had an illegal or compiled-out format.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Decode is combinational on the input side. The bit mapping, before extension, is:
  - I: {instr[31:20]}.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
- Every format is sign-extended from instr[31] to XLEN. For XLEN=64, U also sign-extends from bit 31.
- An illegal format gives imm=0 and illegal=1. A legal format gives illegal=0.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. It is a combinational function of state and flush only; it does not depend on out_ready.
- out_valid = (count != 0).
- When the queue is empty, out_imm, out_tag and out_illegal are forced to 0.
- Storage is a circular buffer with wr_ptr and rd_ptr of width $clog2(DEPTH), plus count.
  - Both pointers wrap from DEPTH-1 to 0.
  - Push and pop in the same cycle leave count unchanged; both pointers advance.
- flush has priority over everything else: count, wr_ptr and rd_ptr go to 0. Any same-cycle pop is void, and no push can occur because in_ready is low.
- Reset (async assert, any cycle, including mid-transfer) clears count and both pointers. Storage contents are not reset.
- Values after reset: in_ready=1, out_valid=0, out_imm=0, out_tag=0, out_illegal=0, count=0.

## Timing
- Latency is 1 cycle. A word pushed at edge k appears at the head with out_valid=1 from edge k onward, provided the queue was empty.
- There is no combinational path from in_* to out_*. The only input-to-output combinational path is flush -> in_ready.
- Full throughput is one word per cycle while out_ready is held high.
- At full (count=DEPTH), in_ready=0. A pop in that cycle frees a slot visible from the next cycle; there is no same-cycle bypass.
- At empty, out_ready is ignored and count never underflows.
- Deassertion of rst_n is expected to be synchronised externally. The first push is allowed on the first edge after release.

## Configuration
- IMM_GEN_UTYPE_EN defined: in_imm_src=4 decodes the U-type immediate as above.
- IMM_GEN_UTYPE_EN undefined: in_imm_src=4 is treated like 5–7 (imm=0, out_illegal=1). The U-type extraction logic is not compiled.

## Test plan
- Reset then single I push: in_instr=0xFFF00093, src=0, XLEN=32 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0, count=1; pop -> count=0, out_imm=0.
- Per-format decode:
  - B with in_instr=0xFE000EE3 -> out_imm=0xFFFFFFFC.
  - J with 0x0040006F -> 0x00000004.
  - S with 0x00112623 -> 0x0000000C.
  - U with 0x123450B7 -> 0x12345000 when the macro is defined; when it is not, out_imm=0 and out_illegal=1.
- Backpressure with DEPTH=2 and out_ready=0: push 3 words -> third is held off by in_ready=0 and count=2. Raise out_ready -> the three words drain in order with their tags 1, 2, 3. Pointers wrap with no loss.
- Simultaneous push/pop with count=1 for 10 cycles -> count stays 1 and the tag sequence is preserved.
- flush with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle input is not enqueued. Separately, assert rst_n=0 mid-stream -> outputs go to reset values immediately, without waiting for an edge.
- XLEN=64, I with in_instr=0x80000013 -> out_imm=0xFFFFFFFFFFFFF800; illegal src=6 -> out_imm=0, out_illegal=1.

Source files
------------

// File: rtl/imm_gen_fifo_if.sv
// Handshake bundle for imm_gen_fifo: producer-side instruction words in,
// decoded immediates with tag and illegal flag out.
interface imm_gen_fifo_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_fifo.sv
// RISC-V immediate decoder feeding a DEPTH-entry circular FIFO of {imm, tag, illegal}.
// Define IMM_GEN_UTYPE_EN to decode in_imm_src=4 as U-type; otherwise it is illegal.
module imm_gen_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    imm_gen_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [31:0]      decImm32;
    logic             decIllegal;
    logic [XLEN-1:0]  decImm;

    logic [XLEN-1:0]  immMem_q [DEPTH];
    logic [TAG_W-1:0] tagMem_q [DEPTH];
    logic             illMem_q [DEPTH];

    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW:0]      count_q, count_d;

    logic             push;
    logic             pop;
    logic             outValid;
    logic             unused_instr_bits;

    // Every format is first built as a 32-bit value sign-extended from instr[31].
    always_comb begin
        decImm32   = '0;
        decIllegal = 1'b0;
        case (bus.in_imm_src)
            3'd0: decImm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            3'd1: decImm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            3'd2: decImm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                              bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            3'd3: decImm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                              bus.in_instr[20], bus.in_instr[30:21], 1'b0};
`ifdef IMM_GEN_UTYPE_EN
            3'd4: decImm32 = {bus.in_instr[31:12], 12'b0};
`endif
            default: decIllegal = 1'b1;
        endcase
    end

    assign decImm            = XLEN'($signed(decImm32));
    assign unused_instr_bits = ^bus.in_instr[6:0];

    assign bus.in_ready = (count_q < FULL) && !flush;
    assign outValid     = (count_q != '0);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = outValid && bus.out_ready;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + 1'b1;
            if (pop)  rdPtr_d = rdPtr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            immMem_q[wrPtr_q] <= decImm;
            tagMem_q[wrPtr_q] <= bus.in_tag;
            illMem_q[wrPtr_q] <= decIllegal;
        end
    end

    assign bus.out_valid   = outValid;
    assign bus.out_imm     = outValid ? immMem_q[rdPtr_q] : '0;
    assign bus.out_tag     = outValid ? tagMem_q[rdPtr_q] : '0;
    assign bus.out_illegal = outValid ? illMem_q[rdPtr_q] : 1'b0;
    assign count           = count_q;
endmodule

// File: tb/tb_imm_gen_fifo.sv
// Self-checking bench for imm_gen_fifo: XLEN=32 and XLEN=64 instances driven in lockstep
// against a scoreboard queue, with a decode vector table plus multi-cycle corner sequences.
module tb_imm_gen_fifo;
    localparam int DEPTH = 2;
    localparam int TAG_W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [1:0] count32;
    logic [1:0] count64;

    always #5 clk = ~clk;

    imm_gen_fifo_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
    imm_gen_fifo_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

    imm_gen_fifo #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus32),
        .count (count32)
    );

    imm_gen_fifo #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64),
        .count (count64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } entry_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [7:0]  tag;
        logic [63:0] expImm;
        logic        expIll;
    } vector_t;

    entry_t sb[$];
    int     checks   = 0;
    int     failures = 0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written as bit overwrites on a sign-filled word.
    function automatic void refDecode(input logic [31:0] instr, input logic [2:0] src,
                                      output logic [63:0] imm, output logic ill);
        logic [31:0] r;
        r   = {32{instr[31]}};
        ill = 1'b0;
        case (src)
            3'd0: r[11:0] = instr[31:20];
            3'd1: begin r[11:5] = instr[31:25]; r[4:0] = instr[11:7]; end
            3'd2: begin r[11] = instr[7]; r[10:5] = instr[30:25]; r[4:1] = instr[11:8]; r[0] = 1'b0; end
            3'd3: begin r[19:12] = instr[19:12]; r[11] = instr[20]; r[10:1] = instr[30:21]; r[0] = 1'b0; end
`ifdef IMM_GEN_UTYPE_EN
            3'd4: begin r[31:12] = instr[31:12]; r[11:0] = 12'h000; end
`endif
            default: begin r = 32'h0; ill = 1'b1; end
        endcase
        imm = {{32{r[31]}}, r};
    endfunction

    task automatic checkOutput(input logic fl);
        entry_t      head;
        logic [63:0] expReady;
        logic [63:0] expValid;
        head     = '0;
        if (sb.size() > 0) head = sb[0];
        expReady = 64'(!fl && (sb.size() < DEPTH));
        expValid = 64'(sb.size() != 0);
        checkVal("in_ready32",    64'(bus32.in_ready),    expReady);
        checkVal("out_valid32",   64'(bus32.out_valid),   expValid);
        checkVal("out_imm32",     64'(bus32.out_imm),     {32'h0, head.imm[31:0]});
        checkVal("out_tag32",     64'(bus32.out_tag),     64'(head.tag));
        checkVal("out_illegal32", 64'(bus32.out_illegal), 64'(head.ill));
        checkVal("count32",       64'(count32),           64'(sb.size()));
        checkVal("in_ready64",    64'(bus64.in_ready),    expReady);
        checkVal("out_valid64",   64'(bus64.out_valid),   expValid);
        checkVal("out_imm64",     bus64.out_imm,          head.imm);
        checkVal("out_tag64",     64'(bus64.out_tag),     64'(head.tag));
        checkVal("out_illegal64", 64'(bus64.out_illegal), 64'(head.ill));
        checkVal("count64",       64'(count64),           64'(sb.size()));
    endtask

    // Called at a falling edge; checks the current state, then models the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [2:0] src,
                                 input logic [7:0] tag, input logic oRdy, input logic fl,
                                 input logic [63:0] expImm, input logic expIll);
        logic   accept;
        entry_t e;
        bus32.in_valid = v;  bus32.in_instr = instr; bus32.in_imm_src = src;
        bus32.in_tag   = tag; bus32.out_ready = oRdy;
        bus64.in_valid = v;  bus64.in_instr = instr; bus64.in_imm_src = src;
        bus64.in_tag   = tag; bus64.out_ready = oRdy;
        flush = fl;
        #1;
        checkOutput(fl);
        accept = v && !fl && (sb.size() < DEPTH);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (oRdy && sb.size() > 0) void'(sb.pop_front());
            if (accept) begin
                e.imm = expImm;
                e.tag = tag;
                e.ill = expIll;
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] instr, input logic [2:0] src, input logic [7:0] tag,
                            input logic oRdy, input logic fl);
        logic [63:0] imm;
        logic        ill;
        refDecode(instr, src, imm, ill);
        applyStimulus(1'b1, instr, src, tag, oRdy, fl, imm, ill);
    endtask

    task automatic idle(input logic oRdy);
        applyStimulus(1'b0, 32'h0, 3'd0, 8'h00, oRdy, 1'b0, 64'h0, 1'b0);
    endtask

    vector_t vec[12];

    initial begin
        vec[0]  = '{32'hFFF00093, 3'd0, 8'h01, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vec[1]  = '{32'h7FF00013, 3'd0, 8'h02, 64'h00000000_000007FF, 1'b0};
        vec[2]  = '{32'h80000013, 3'd0, 8'h03, 64'hFFFFFFFF_FFFFF800, 1'b0};
        vec[3]  = '{32'h00112623, 3'd1, 8'h04, 64'h00000000_0000000C, 1'b0};
        vec[4]  = '{32'h80000023, 3'd1, 8'h05, 64'hFFFFFFFF_FFFFF800, 1'b0};
        vec[5]  = '{32'hFE000EE3, 3'd2, 8'h06, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vec[6]  = '{32'h80000063, 3'd2, 8'h07, 64'hFFFFFFFF_FFFFF000, 1'b0};
        vec[7]  = '{32'h0040006F, 3'd3, 8'h08, 64'h00000000_00000004, 1'b0};
        vec[8]  = '{32'h800000EF, 3'd3, 8'h09, 64'hFFFFFFFF_FFF00000, 1'b0};
        vec[9]  = '{32'hFFF00093, 3'd6, 8'h0A, 64'h0, 1'b1};
`ifdef IMM_GEN_UTYPE_EN
        vec[10] = '{32'h123450B7, 3'd4, 8'h0B, 64'h00000000_12345000, 1'b0};
        vec[11] = '{32'h800000B7, 3'd4, 8'h0C, 64'hFFFFFFFF_80000000, 1'b0};
`else
        vec[10] = '{32'h123450B7, 3'd4, 8'h0B, 64'h0, 1'b1};
        vec[11] = '{32'h800000B7, 3'd7, 8'h0C, 64'h0, 1'b1};
`endif

        rst_n = 1'b0;
        flush = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_imm_src = '0;
        bus32.in_tag   = '0;   bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_imm_src = '0;
        bus64.in_tag   = '0;   bus64.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput(1'b0);
        rst_n = 1'b1;

        $display("[TB] single I push then pop");
        sendWord(32'hFFF00093, 3'd0, 8'hA5, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] decode vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vec[i].instr, vec[i].src, vec[i].tag, 1'b1, 1'b0,
                          vec[i].expImm, vec[i].expIll);
        end
        idle(1'b1);

        $display("[TB] backpressure and wrap");
        sendWord(32'h00112623, 3'd1, 8'h01, 1'b0, 1'b0);
        sendWord(32'hFE000EE3, 3'd2, 8'h02, 1'b0, 1'b0);
        sendWord(32'h0040006F, 3'd3, 8'h03, 1'b0, 1'b0);
        sendWord(32'h0040006F, 3'd3, 8'h03, 1'b1, 1'b0);
        sendWord(32'h0040006F, 3'd3, 8'h03, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] simultaneous push and pop");
        sendWord(32'h7FF00013, 3'd0, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sendWord($urandom, 3'(i % 5), 8'(8'h21 + i), 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("[TB] flush with full queue");
        sendWord(32'h80000013, 3'd0, 8'h40, 1'b0, 1'b0);
        sendWord(32'h80000023, 3'd1, 8'h41, 1'b0, 1'b0);
        sendWord(32'hFE000EE3, 3'd2, 8'h42, 1'b1, 1'b1);
        idle(1'b1);
        sendWord(32'h00112623, 3'd1, 8'h43, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] asynchronous reset mid-stream");
        sendWord(32'hFFF00093, 3'd0, 8'h50, 1'b0, 1'b0);
        sendWord(32'h0040006F, 3'd3, 8'h51, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sendWord(32'h800000EF, 3'd3, 8'h60, 1'b0, 1'b0);
        sendWord(32'h00000013, 3'd5, 8'h61, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
